fxu_result_stage: RTL and testbench

Registered result/write-back stage directly downstream of the count-leading-zeros unit in the fixed-point execution path. Each cycle it accepts one result word, its CR field, the destination GPR index and the record-form flag under a valid/ready handshake. It holds the entry for the write-back arbiter and builds the final CR0 value by merging XER[SO] into the CR field. It decouples the combinational cntlz/ALU logic from GPR and CR write-back timing.

---
 rtl/fxu_result_stage_if.sv | 17 +
 rtl/fxu_result_stage.sv | 66 ++++++
 tb/tb_fxu_result_stage.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fxu_result_stage_if.sv
// fxu_result_stage_if: upstream-result and write-back handshake bundle.
// Word is 32 bits; CR fields are packed {lt, gt, eq, so}.
interface fxu_result_stage_if #(parameter int RT_WIDTH = 5);
  logic                in_valid, in_ready, in_record, in_xer_so;
  logic [31:0]         in_result, wb_result;
  logic [3:0]          in_crout, wb_cr;
  logic [RT_WIDTH-1:0] in_rt, wb_rt;
  logic                wb_valid, wb_ready, wb_cr_we;
  modport master (
    output in_valid, in_result, in_crout, in_rt, in_record, in_xer_so, wb_ready,
    input  in_ready, wb_valid, wb_result, wb_rt, wb_cr_we, wb_cr
  );
  modport slave (
    input  in_valid, in_result, in_crout, in_rt, in_record, in_xer_so, wb_ready,
    output in_ready, wb_valid, wb_result, wb_rt, wb_cr_we, wb_cr
  );
endinterface

// File: rtl/fxu_result_stage.sv
// fxu_result_stage: registered cntlz/ALU write-back stage merging XER[SO] into CR0 at capture.
// Define FXU_RESULT_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module fxu_result_stage #(parameter int RT_WIDTH = 5) (
  input logic                clk,
  input logic                reset,
  input logic                flush,
  fxu_result_stage_if.slave  bus
);
  typedef struct packed {
    logic [31:0]         result;
    logic [RT_WIDTH-1:0] rt;
    logic [3:0]          cr;
    logic                rec;
  } entry_t;
  // bit0 = main valid, bit1 = skid valid
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11} state_t;
  state_t r_state, w_next;
  entry_t r_main, w_entry, w_main_next;
  logic   w_in, w_out, w_load_main;
  logic [3:0] w_cr;
  assign w_in = bus.in_valid & bus.in_ready;
  assign w_out = r_state[0] & bus.wb_ready;
  assign w_cr = bus.in_record ? ((bus.in_crout & 4'b1110) | {3'b000, bus.in_xer_so}) : 4'b0000;
  assign w_entry = {bus.in_result, bus.in_rt, w_cr, bus.in_record};
`ifdef FXU_RESULT_SKID_EN
  entry_t r_skid;
  assign bus.in_ready = ~r_state[1];
  always_ff @(posedge clk or posedge reset)
    if (reset) r_skid <= '0;
    else if (r_state == ONE && w_in && !w_out) r_skid <= w_entry;
  assign w_main_next = w_load_main ? w_entry : (r_state == FULL && w_out) ? r_skid : r_main;
`else
  assign bus.in_ready = ~r_state[0] | bus.wb_ready;
  assign w_main_next = w_load_main ? w_entry : r_main;
`endif
  always_comb begin
    w_next = r_state;
    w_load_main = 1'b0;
    case (r_state)
      EMPTY: begin
        w_next = w_in ? ONE : EMPTY;
        w_load_main = w_in;
      end
      ONE: begin
        w_next = w_in ? (w_out ? ONE : FULL) : (w_out ? EMPTY : ONE);
        w_load_main = w_in & w_out;
      end
      FULL: w_next = w_out ? ONE : FULL;
      default: w_next = EMPTY;
    endcase
    if (flush) w_next = EMPTY;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= EMPTY;
      r_main <= '0;
    end else begin
      r_state <= w_next;
      r_main <= w_main_next;
    end
  assign bus.wb_valid = r_state[0];
  assign bus.wb_result = r_main.result;
  assign bus.wb_rt = r_main.rt;
  assign bus.wb_cr = r_main.cr;
  assign bus.wb_cr_we = r_state[0] & r_main.rec;
endmodule

// File: tb/tb_fxu_result_stage.sv
// tb_fxu_result_stage: scoreboard bench; driver queues expected write-backs, monitor pops and compares.
module tb_fxu_result_stage;
  logic clk, reset, flush;
  fxu_result_stage_if #(.RT_WIDTH(5)) b();
  fxu_result_stage #(.RT_WIDTH(5)) dut (.clk(clk), .reset(reset), .flush(flush), .bus(b));

  typedef struct {logic [31:0] res; logic [4:0] rt; logic [3:0] cr; logic we;} exp_t;
  exp_t q[$];
  exp_t e_s;
  logic acc = 1'b0, fl_s = 1'b0;
  int n_tests = 0, n_fail = 0, n_rst = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // One cycle: commit last cycle's handshake into the model, drive new inputs, sample acceptance.
  task automatic step(input logic v, input logic [31:0] r, input logic [3:0] c, input logic [4:0] t,
                      input logic rec, input logic so, input logic wr, input logic fl);
    @(posedge clk);
    if (fl_s) q.delete();
    else if (acc) q.push_back(e_s);
    #1;
    b.in_valid = v; b.in_result = r; b.in_crout = c; b.in_rt = t;
    b.in_record = rec; b.in_xer_so = so; b.wb_ready = wr & ~fl; flush = fl;
    @(negedge clk);
    acc = v & b.in_ready;
    fl_s = fl;
    e_s = '{r, t, rec ? {c[3:1], so} : 4'b0000, rec};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: occupancy, handshake and head-entry checks against the model queue.
  initial begin
    logic [41:0] snap;
    logic stall_p;
    int rst_p;
    stall_p = 1'b0;
    rst_p = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("wb_valid", b.wb_valid, q.size() > 0);
`ifdef FXU_RESULT_SKID_EN
        chk("in_ready", b.in_ready, q.size() < 2);
`else
        chk("in_ready", b.in_ready, q.size() == 0 || b.wb_ready);
`endif
        if (stall_p && rst_p == n_rst)
          chk("stall_stable", {b.wb_result, b.wb_rt, b.wb_cr, b.wb_cr_we}, snap);
        if (b.wb_valid && q.size() > 0) begin
          chk("wb_result", b.wb_result, q[0].res);
          chk("wb_rt", b.wb_rt, q[0].rt);
          chk("wb_cr", b.wb_cr, q[0].cr);
          chk("wb_cr_we", b.wb_cr_we, q[0].we);
          if (b.wb_ready) void'(q.pop_front());
        end
        stall_p = b.wb_valid & ~b.wb_ready & ~flush;
        snap = {b.wb_result, b.wb_rt, b.wb_cr, b.wb_cr_we};
        rst_p = n_rst;
      end else stall_p = 1'b0;
    end
  end

  initial begin
    int g;
    reset = 1'b1; flush = 1'b0;
    b.in_valid = 0; b.in_result = 0; b.in_crout = 0; b.in_rt = 0;
    b.in_record = 0; b.in_xer_so = 0; b.wb_ready = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_wb_valid", b.wb_valid, 0);
    chk("rst_wb_cr_we", b.wb_cr_we, 0);
    chk("rst_wb_result", b.wb_result, 0);
    chk("rst_wb_rt", b.wb_rt, 0);
    chk("rst_wb_cr", b.wb_cr, 0);
    chk("rst_in_ready", b.in_ready, 1);
    // cntlz result 32 with gt and SO set, then record-form off
    step(1, 32'h20, 4'b0100, 5'd7, 1, 1, 1, 0);
    step(1, 32'h11, 4'b0010, 5'd9, 0, 1, 1, 0);
    idle(3);
    // back-pressure stream 0..3 with wb_ready low for 3 cycles
    g = 0;
    for (int k = 0; k < 4; k++) begin
      do begin
        step(1, k, 4'b1000, 5'(k + 1), 1, 0, g >= 3, 0);
        g++;
      end while (!acc && g < 30);
      if (!acc) chk("accept_timeout", 0, 1);
    end
    idle(5);
    // flush while holding entries, with a valid input in the flush cycle
    step(1, 32'hA, 4'b0010, 5'd1, 1, 0, 0, 0);
    step(1, 32'hB, 4'b0010, 5'd2, 1, 0, 0, 0);
    step(1, 32'hC, 4'b0010, 5'd3, 1, 1, 0, 1);
    idle(3);
    // asynchronous reset while an entry is held
    step(1, 32'h5, 4'b0100, 5'd4, 1, 1, 0, 0);
    step(0, 32'h0, 4'h0, 5'd0, 0, 0, 0, 0);
    chk("pre_reset_valid", b.wb_valid, 1);
    #2 reset = 1'b1;
    b.in_valid = 1'b0;
    n_rst++;
    #1;
    chk("async_wb_valid", b.wb_valid, 0);
    chk("async_wb_cr_we", b.wb_cr_we, 0);
    chk("async_wb_result", b.wb_result, 0);
    q.delete(); acc = 1'b0; fl_s = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    step(1, 32'h1F, 4'b1000, 5'd31, 1, 0, 1, 0);
    idle(3);
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(3) != 0, $urandom, 4'($urandom), 5'($urandom), 1'($urandom),
           1'($urandom), $urandom_range(2) != 0, $urandom_range(39) == 0);
    idle(6);
    chk("drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
